// File: rtl/conv_pkg.sv
// Shared constants, state encoding and the 8-bit clamp used by the 3x3
// convolution window multiplier and the downstream adder tree.
package conv_pkg;

  localparam int KSIZE   = 3;
  localparam int NTAPS   = KSIZE * KSIZE;
  localparam int PIX_W   = 8;
  localparam int PROD_W  = 16;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Drain down-counter load; DRAIN spans load..0 inclusive.
  localparam logic [1:0] DRAIN_LOAD = 2'd3;

  typedef logic signed [PIX_W-1:0]  pix_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  function automatic pix_t sat8(input prod_t v);
    if (v > prod_t'(SAT_MAX)) return pix_t'(SAT_MAX);
    if (v < prod_t'(SAT_MIN)) return pix_t'(SAT_MIN);
    return pix_t'(v[PIX_W-1:0]);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular delay line of DEPTH entries: output is the sample written DEPTH
// shifts ago (read-before-write on a single pointer).
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  assign o_dout = r_mem[r_ptr];

  // RAM contents deliberately survive reset; row/col gating hides stale data.
  always_ff @(posedge clk) begin
    if (i_shift_en) r_mem[r_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_shift_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_mult.sv
// 3x3 sliding-window multiplier: line buffers build raster windows, each tap is
// multiplied by its kernel weight, rescaled, clamped and handed to the adder tree.
//
// state    | meaning
// ST_IDLE  | waiting for the first pixel; weight loads honoured
// ST_RUN   | streaming the pixels of a frame
// ST_DRAIN | four cycles after the last pixel: last window, then two zero flushes
module conv_window_mult
  import conv_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int FRAC_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_load,
  input  logic signed [7:0] w_data,
  output logic             weights_ok,
  input  logic             pix_valid,
  input  logic signed [7:0] pix_in,
  output logic             pix_ready,
  output logic             tree,
  output logic signed [7:0] result_0,
  output logic signed [7:0] result_1,
  output logic signed [7:0] result_2,
  output logic signed [7:0] result_3,
  output logic signed [7:0] result_4,
  output logic signed [7:0] result_5,
  output logic signed [7:0] result_6,
  output logic signed [7:0] result_7,
  output logic signed [7:0] result_8
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [1:0]       r_state;
  logic [1:0]       r_drain_cnt;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  pix_t             r_w [NTAPS];
  logic [3:0]       r_idx;
  logic             r_wok;
  pix_t             r_win [NTAPS];
  logic             r_win_vld;
  pix_t             r_res [NTAPS];
  logic             r_tree;

  logic             w_accept;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_last_pix;
  logic             w_flush;
  logic [PIX_W-1:0] w_lb0_out;
  logic [PIX_W-1:0] w_lb1_out;
  prod_t            w_prod [NTAPS];
  pix_t             w_sat  [NTAPS];

  assign pix_ready  = r_wok && (r_state != ST_DRAIN);
  assign weights_ok = r_wok;
  assign tree       = r_tree;
  assign w_accept   = pix_valid && pix_ready;
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_row_end  = (r_row == RW'(IMG_H - 1));
  assign w_last_pix = w_accept && w_col_end && w_row_end;
  assign w_flush    = (r_state == ST_DRAIN) && ((r_drain_cnt == 2'd2) || (r_drain_cnt == 2'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_RUN;
        ST_RUN: begin
          if (w_last_pix) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'd0) r_state <= ST_IDLE;
          else                     r_drain_cnt <= r_drain_cnt - 2'd1;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // A load while weights_ok is set starts a fresh kernel at w0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_wok <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_w[i] <= '0;
    end else if (w_load && (r_state == ST_IDLE)) begin
      if (r_wok) begin
        r_w[0] <= w_data;
        r_idx  <= 4'd1;
        r_wok  <= 1'b0;
      end else begin
        r_w[r_idx] <= w_data;
        if (r_idx == 4'(NTAPS - 1)) begin
          r_idx <= '0;
          r_wok <= 1'b1;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .i_shift_en(w_accept), .i_din(pix_in), .o_dout(w_lb0_out)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .i_shift_en(w_accept), .i_din(w_lb0_out), .o_dout(w_lb1_out)
  );

  // Row 0 of the window is oldest (two lines back), column 0 is leftmost.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        r_win[r*KSIZE]     <= r_win[r*KSIZE + 1];
        r_win[r*KSIZE + 1] <= r_win[r*KSIZE + 2];
      end
      r_win[KSIZE - 1]   <= pix_t'(w_lb1_out);
      r_win[2*KSIZE - 1] <= pix_t'(w_lb0_out);
      r_win[NTAPS - 1]   <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_win_vld <= 1'b0;
    else     r_win_vld <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
  end

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      w_prod[i] = prod_t'(r_win[i]) * prod_t'(r_w[i]);
      w_sat[i]  = sat8(w_prod[i] >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tree <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_res[i] <= '0;
    end else if (w_flush) begin
      r_tree <= 1'b1;
      for (int i = 0; i < NTAPS; i++) r_res[i] <= '0;
    end else if (r_win_vld) begin
      r_tree <= 1'b1;
      for (int i = 0; i < NTAPS; i++) r_res[i] <= w_sat[i];
    end else begin
      r_tree <= 1'b0;
    end
  end

  assign result_0 = r_res[0];
  assign result_1 = r_res[1];
  assign result_2 = r_res[2];
  assign result_3 = r_res[3];
  assign result_4 = r_res[4];
  assign result_5 = r_res[5];
  assign result_6 = r_res[6];
  assign result_7 = r_res[7];
  assign result_8 = r_res[8];

endmodule
